acia_tx: RTL and testbench
==========================

# acia_tx

Serial transmitter that forms the other end of the ACIA serial link: it takes bytes from a parallel handshake and drives an asynchronous start/data/parity/stop frame on one line. It runs in the system clock domain and paces bits with the one-cycle peripheral-clock enable generated in `soc_65xx`. Its line output is framed so that `acia_rx` with matching parameters receives it; `acia_rx` is also the simulation monitor for it. A one-byte holding register in front of the shift register gives back-to-back frames with no idle gap.

## Interface
Parameters:
- `clk_freq`, default 3333333: rate of `pclk` enable pulses, in Hz.
- `sym_rate`, default 115200: baud rate, in Hz.
- `PARITY`, default 0: parity mode. 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: reset, synchronous, active-high.
- `pclk` in 1: one-`clk`-cycle baud enable.
- `tx_dat` in 8: byte to send, LSB first.
- `tx_stb` in 1: write strobe. Accepted only when `tx_rdy`=1.
- `tx_rdy` out 1: holding register empty.
- `tx_busy` out 1: frame in progress.
- `tx_ovr` out 1: one-cycle pulse when `tx_stb` arrives while `tx_rdy`=0.
- `tx_serial` out 1: serial line, idles high.

## Operation
- Divisor: `DIV = (clk_freq + sym_rate/2) / sym_rate`, rounded to nearest. Defaults give `DIV`=29.
- Counter width is `$clog2(DIV)`. Each bit lasts exactly `DIV` `pclk` pulses.
- Holding register:
  - `tx_stb` while `tx_rdy`=1 latches `tx_dat` and clears `tx_rdy` on the next edge.
  - `tx_stb` while `tx_rdy`=0 is ignored, the held byte is kept, and `tx_ovr` pulses.
- State machine: IDLE, START, DATA, PARITY, STOP.
  - IDLE to START occurs when the holding register is full and `pclk`=1. On that edge the byte moves to the shift register, `tx_rdy` sets to 1, `tx_serial` goes to 0 and `tx_busy` goes to 1.
  - START to DATA after `DIV` pulses.
  - DATA shifts out 8 bits, LSB first, then goes to PARITY. If `PARITY`=0 it goes to STOP instead.
  - PARITY sends one bit: XOR of the data for even, its inverse for odd. Then STOP.
  - STOP holds `tx_serial`=1 for `STOP_BITS`×`DIV` pulses.
- End of the last stop bit:
  - If the holding register is full, go straight to START on the same edge, with no idle gap.
  - Otherwise go to IDLE and `tx_busy` drops to 0.
- Simultaneous events:
  - `tx_stb` on the same edge as the hold-to-shift transfer is rejected, because `tx_rdy` was 0 in that cycle, and `tx_ovr` pulses.
  - `pclk` with no pending data in IDLE: no action.
- Reset mid-frame: the frame is truncated. All state clears and the line returns high on the next edge.

## Timing
- Reset values: `tx_serial`=1, `tx_rdy`=1, `tx_busy`=0, `tx_ovr`=0. State is IDLE, counters are 0, the holding register is empty.
- All outputs are registered. No combinational path from inputs to outputs.
- Latency from `tx_stb` to the start-bit edge is 1 `clk` cycle, plus a wait for the next `pclk` pulse after the holding register is loaded.
- Frame length is `(1 + 8 + (PARITY!=0) + STOP_BITS) × DIV` `pclk` pulses. With defaults: 10×29 = 290.
- `tx_rdy` returns to 1 at the start of a frame. Software may therefore queue the next byte a whole frame ahead.

## Structure
- Shared header `acia_defs.vh`, also used by `acia_rx`, holds:
  - state encodings (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4);
  - parity mode constants (`PAR_NONE`, `PAR_EVEN`, `PAR_ODD`);
  - the rounded divisor formula.
- Sub-module `acia_baud_tick`: counts `pclk` pulses up to `DIV`. It is restarted by the FSM at the start bit and outputs a one-cycle `bit_end`. `acia_rx` can reuse it.
- Top-level pieces: a holding register, an 8-bit shift register, a 3-bit bit counter and a stop-bit counter.

## Test plan
1. Reset checks:
   - Assert `reset` for 3 cycles → `tx_serial`=1, `tx_rdy`=1, `tx_busy`=0.
   - Release with no `tx_stb` → line stays high indefinitely.
2. Single byte, `pclk` tied to 1, `clk_freq`=10, `sym_rate`=1 (`DIV`=10). Strobe `tx_dat`=8'hA5 → line is 0, then 1,0,1,0,0,1,0,1, then 1, each level lasting 10 cycles. `tx_busy` is high for 100 cycles. `acia_rx` loopback returns 8'hA5 with `rx_err`=0.
3. Back-to-back: strobe 8'h55, then 8'hC3 as soon as `tx_rdy` rises → no idle gap between the stop bit and the next start bit, and `tx_ovr` never pulses.
4. Overrun: strobe 8'h11 and 8'h22 on consecutive cycles while busy with 8'h00 → the second strobe pulses `tx_ovr` once. Frames sent are 8'h00 then 8'h11. 8'h22 is not sent.
5. Parity and stop bits: `PARITY`=1, `STOP_BITS`=2, byte 8'h07 → parity bit 1, followed by 20 high cycles.
6. Reset mid-frame: assert `reset` during data bit 3 of 8'hFF → `tx_serial`=1 the next cycle, `tx_rdy`=1, and no further transitions occur.

Source files
------------

// File: rtl/acia_tx_pkg.sv
// Shared definitions for the ACIA serial link: state encodings, parity modes
// and the rounded baud divisor.
package acia_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Number of pclk pulses per bit, rounded to nearest.
    function automatic int calc_div(input int clk_freq, input int sym_rate);
        return (clk_freq + sym_rate / 2) / sym_rate;
    endfunction

    // Width of a counter that spans 0..div-1 (at least one bit).
    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/acia_tx_baud_tick.sv
// Bit-period timer: counts pclk pulses and flags the pulse that ends a bit.
// Held at zero while restart is high so the first bit starts on a clean count.
module acia_tx_baud_tick
    import acia_tx_pkg::*;
#(
    parameter int DIV = 29
) (
    input  logic clk,
    input  logic reset,
    input  logic pclk,
    input  logic restart,
    output logic bit_end
);

    localparam int            CW   = cnt_width(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign bit_end = pclk && (cnt_q == LAST);

    // Next count: hold at zero on restart, wrap at the end of each bit.
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (pclk) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/acia_tx.sv
// ACIA serial transmitter: one-byte holding register feeding a shift register
// that drives start / 8 data (LSB first) / optional parity / stop bits.
module acia_tx
    import acia_tx_pkg::*;
#(
    parameter int clk_freq  = 3333333,
    parameter int sym_rate  = 115200,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pclk,
    input  logic [7:0] tx_dat,
    input  logic       tx_stb,
    output logic       tx_rdy,
    output logic       tx_busy,
    output logic       tx_ovr,
    output logic       tx_serial
);

    localparam int   DIV       = calc_div(clk_freq, sym_rate);
    localparam logic LAST_STOP = (STOP_BITS == 2);

    tx_state_e  state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       rdy_q, rdy_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic       stopcnt_q, stopcnt_d;
    logic       par_q, par_d;
    logic       serial_q, serial_d;
    logic       busy_q, busy_d;
    logic       ovr_q, ovr_d;
    logic       load;
    logic       restart;
    logic       bit_end;

    assign restart = (state_q == ST_IDLE);

    acia_tx_baud_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .pclk    (pclk),
        .restart (restart),
        .bit_end (bit_end)
    );

    assign tx_rdy    = rdy_q;
    assign tx_busy   = busy_q;
    assign tx_ovr    = ovr_q;
    assign tx_serial = serial_q;

    // Next-state logic: frame sequencing, holding-register handshake, overrun.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        rdy_d     = rdy_q;
        shift_d   = shift_q;
        bitcnt_d  = bitcnt_q;
        stopcnt_d = stopcnt_q;
        par_d     = par_q;
        serial_d  = serial_q;
        busy_d    = busy_q;
        ovr_d     = 1'b0;
        load      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!rdy_q && pclk) begin
                    load = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d  = ST_DATA;
                    serial_d = shift_q[0];
                    shift_d  = shift_q >> 1;
                    bitcnt_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bitcnt_q == 3'd7) begin
                        if (PARITY != PAR_NONE) begin
                            state_d  = ST_PARITY;
                            serial_d = par_q;
                        end else begin
                            state_d   = ST_STOP;
                            serial_d  = 1'b1;
                            stopcnt_d = 1'b0;
                        end
                    end else begin
                        serial_d = shift_q[0];
                        shift_d  = shift_q >> 1;
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d   = ST_STOP;
                    serial_d  = 1'b1;
                    stopcnt_d = 1'b0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (stopcnt_q == LAST_STOP) begin
                        // A queued byte starts on this same edge: no idle gap.
                        if (!rdy_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        stopcnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Hold-to-shift transfer; the parity bit is fixed from the byte here.
        if (load) begin
            state_d  = ST_START;
            shift_d  = hold_q;
            par_d    = (^hold_q) ^ (PARITY == PAR_ODD);
            rdy_d    = 1'b1;
            serial_d = 1'b0;
            busy_d   = 1'b1;
        end

        // A strobe is only taken when the holding register was empty this cycle.
        if (tx_stb) begin
            if (rdy_q) begin
                hold_d = tx_dat;
                rdy_d  = 1'b0;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // State and output registers; reset truncates any frame and idles the line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            hold_q    <= 8'h00;
            rdy_q     <= 1'b1;
            shift_q   <= 8'h00;
            bitcnt_q  <= 3'd0;
            stopcnt_q <= 1'b0;
            par_q     <= 1'b0;
            serial_q  <= 1'b1;
            busy_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            rdy_q     <= rdy_d;
            shift_q   <= shift_d;
            bitcnt_q  <= bitcnt_d;
            stopcnt_q <= stopcnt_d;
            par_q     <= par_d;
            serial_q  <= serial_d;
            busy_q    <= busy_d;
            ovr_q     <= ovr_d;
        end
    end

endmodule

// File: tb/tb_acia_tx.sv
// Directed bench for acia_tx: two instances (no parity / 1 stop and
// even parity / 2 stop), both with DIV=10 and pclk tied high.
module tb_acia_tx;

    logic       clk;
    logic       reset;
    logic       pclk;
    logic [7:0] tx_dat;
    logic       stb_a, stb_p;
    logic       rdy_a, busy_a, ovr_a, ser_a;
    logic       rdy_p, busy_p, ovr_p, ser_p;

    int n_checks;
    int n_errors;

    logic line_log [0:299];
    logic busy_log [0:299];
    logic rdy_log  [0:299];
    int   ovr_cnt;

    typedef struct {
        logic [7:0] dat;
        logic [9:0] line;   // bit 0 = start bit, bits 1..8 = data, bit 9 = stop
    } vec_t;

    vec_t vecs [5];

    acia_tx #(.clk_freq(10), .sym_rate(1), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .pclk      (pclk),
        .tx_dat    (tx_dat),
        .tx_stb    (stb_a),
        .tx_rdy    (rdy_a),
        .tx_busy   (busy_a),
        .tx_ovr    (ovr_a),
        .tx_serial (ser_a)
    );

    acia_tx #(.clk_freq(10), .sym_rate(1), .PARITY(1), .STOP_BITS(2)) dut_p (
        .clk       (clk),
        .reset     (reset),
        .pclk      (pclk),
        .tx_dat    (tx_dat),
        .tx_stb    (stb_p),
        .tx_rdy    (rdy_p),
        .tx_busy   (busy_p),
        .tx_ovr    (ovr_p),
        .tx_serial (ser_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs n cycles from a negedge, logging the selected DUT at each negedge
    // (j) and driving strobes / reset so they land on the following posedge.
    task automatic capture(input bit sel, input int n,
                           input int s1_j, input logic [7:0] s1_d,
                           input int s2_j, input logic [7:0] s2_d,
                           input int s3_j, input logic [7:0] s3_d,
                           input int rst_j);
        logic stb;
        ovr_cnt = 0;
        for (int j = 0; j < n; j++) begin
            line_log[j] = sel ? ser_p  : ser_a;
            busy_log[j] = sel ? busy_p : busy_a;
            rdy_log[j]  = sel ? rdy_p  : rdy_a;
            if (sel ? ovr_p : ovr_a) ovr_cnt++;
            stb = (j == s1_j) || (j == s2_j) || (j == s3_j);
            tx_dat = (j == s1_j) ? s1_d : (j == s2_j) ? s2_d : s3_d;
            if (sel) stb_p = stb; else stb_a = stb;
            reset = (j == rst_j);
            @(negedge clk);
        end
        stb_a = 1'b0;
        stb_p = 1'b0;
        reset = 1'b0;
    endtask

    function automatic int count_low(input int from, input int to);
        int c = 0;
        for (int j = from; j <= to; j++) if (line_log[j] == 1'b0) c++;
        return c;
    endfunction

    function automatic int count_busy(input int from, input int to);
        int c = 0;
        for (int j = from; j <= to; j++) if (busy_log[j] == 1'b1) c++;
        return c;
    endfunction

    initial begin
        logic [19:0] exp20;
        logic [11:0] exp12;
        logic [7:0]  rx;
        n_checks = 0;
        n_errors = 0;
        pclk   = 1'b1;
        tx_dat = 8'h00;
        stb_a  = 1'b0;
        stb_p  = 1'b0;
        reset  = 1'b1;

        vecs[0] = '{dat: 8'hA5, line: 10'b1101001010};
        vecs[1] = '{dat: 8'h00, line: 10'b1000000000};
        vecs[2] = '{dat: 8'hFF, line: 10'b1111111110};
        vecs[3] = '{dat: 8'h01, line: 10'b1000000010};
        vecs[4] = '{dat: 8'h80, line: 10'b1100000000};

        // Reset for three cycles
        repeat (3) @(negedge clk);
        chk("reset_serial", ser_a, 1);
        chk("reset_rdy", rdy_a, 1);
        chk("reset_busy", busy_a, 0);
        chk("reset_ovr", ovr_a, 0);
        chk("reset_serial_p", ser_p, 1);
        chk("reset_rdy_p", rdy_p, 1);
        reset = 1'b0;
        @(negedge clk);

        // Idle with no strobe: line stays high
        capture(1'b0, 100, -1, 8'h00, -1, 8'h00, -1, 8'h00, -1);
        chk("idle_line_low_cycles", count_low(0, 99), 0);
        chk("idle_busy_cycles", count_busy(0, 99), 0);

        // Single frames from the table
        foreach (vecs[v]) begin
            capture(1'b0, 120, 0, vecs[v].dat, -1, 8'h00, -1, 8'h00, -1);
            chk($sformatf("v%0d_rdy_after_stb", v), rdy_log[1], 0);
            chk($sformatf("v%0d_start_edge", v), line_log[2], 0);
            chk($sformatf("v%0d_pre_start", v), line_log[1], 1);
            chk($sformatf("v%0d_rdy_at_start", v), rdy_log[2], 1);
            for (int i = 0; i < 10; i++)
                chk($sformatf("v%0d_bit%0d", v, i), line_log[7 + 10 * i], vecs[v].line[i]);
            rx = 8'h00;
            for (int k = 0; k < 8; k++) rx[k] = line_log[7 + 10 * (k + 1)];
            chk($sformatf("v%0d_decoded", v), rx, vecs[v].dat);
            chk($sformatf("v%0d_busy_cycles", v), count_busy(0, 119), 100);
            chk($sformatf("v%0d_busy_drop", v), busy_log[102], 0);
            chk($sformatf("v%0d_ovr", v), ovr_cnt, 0);
        end

        // Back-to-back 55 then C3 queued as soon as tx_rdy rises
        exp20 = 20'b1110000110_1010101010;
        capture(1'b0, 230, 0, 8'h55, 2, 8'hC3, -1, 8'h00, -1);
        for (int i = 0; i < 20; i++)
            chk($sformatf("b2b_bit%0d", i), line_log[7 + 10 * i], exp20[i]);
        chk("b2b_no_gap_stop", line_log[101], 1);
        chk("b2b_no_gap_start", line_log[102], 0);
        chk("b2b_busy_cycles", count_busy(0, 229), 200);
        chk("b2b_ovr", ovr_cnt, 0);

        // Overrun: 11 and 22 strobed on consecutive cycles during 00
        exp20 = 20'b1000100010_1000000000;
        capture(1'b0, 250, 0, 8'h00, 20, 8'h11, 21, 8'h22, -1);
        chk("ovr_pulse_count", ovr_cnt, 1);
        for (int i = 0; i < 20; i++)
            chk($sformatf("ovr_bit%0d", i), line_log[7 + 10 * i], exp20[i]);
        chk("ovr_busy_drop", busy_log[205], 0);
        chk("ovr_no_third_frame", count_low(203, 249), 0);

        // Even parity, two stop bits, byte 07
        exp12 = 12'b1110_0000_1110;
        capture(1'b1, 140, 0, 8'h07, -1, 8'h00, -1, 8'h00, -1);
        for (int i = 0; i < 10; i++)
            chk($sformatf("par_bit%0d", i), line_log[7 + 10 * i], exp12[i]);
        chk("par_parity_bit", line_log[97], 1);
        chk("par_stop_low_cycles", count_low(102, 121), 0);
        chk("par_busy_at_last_stop", busy_log[121], 1);
        chk("par_busy_drop", busy_log[122], 0);
        chk("par_busy_cycles", count_busy(0, 139), 120);

        // Reset during data bit 3 of FF
        capture(1'b0, 150, 0, 8'hFF, -1, 8'h00, -1, 8'h00, 45);
        chk("rst_mid_busy_before", busy_log[45], 1);
        chk("rst_mid_serial", line_log[46], 1);
        chk("rst_mid_rdy", rdy_log[46], 1);
        chk("rst_mid_busy", busy_log[46], 0);
        chk("rst_mid_no_transitions", count_low(46, 149), 0);
        chk("rst_mid_busy_after", count_busy(46, 149), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
